// File: rtl/sec32_pkg.sv
// sec32_pkg: widths, check-group masks and parity-pair tables shared by the SEC32 encoder and decoder bench
package sec32_pkg;
    localparam int DATA_W = 32;
    localparam int CHK_W  = 8;
    localparam int CW_W   = DATA_W + CHK_W;
    localparam int NIB_N  = DATA_W / 4;

    localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASK = {
        32'h8888F0F0, 32'h44440F0F, 32'h2222FF00, 32'h111100FF,
        32'hF0F08888, 32'h0F0F4444, 32'hFF002222, 32'h00FF1111
    };

    localparam logic [CHK_W-1:0][2:0] PAR_A = {3'd1, 3'd0, 3'd2, 3'd0, 3'd5, 3'd4, 3'd6, 3'd4};
    localparam logic [CHK_W-1:0][2:0] PAR_B = {3'd3, 3'd2, 3'd3, 3'd1, 3'd7, 3'd6, 3'd7, 3'd5};

    function automatic logic [CHK_W-1:0] check_of(input logic [DATA_W-1:0] d);
        check_of = '0;
        for (int i = 0; i < CHK_W; i++) check_of[i] = ^(d & CHK_MASK[i]);
    endfunction
endpackage

// File: rtl/sec32_check_gen.sv
// sec32_check_gen: nibble parities of one word and check bits from a word plus its registered parities
module sec32_check_gen
    import sec32_pkg::*;
(
    input  logic [DATA_W-1:0] nib_data,
    output logic [NIB_N-1:0]  nib_par,
    input  logic [DATA_W-1:0] chk_data,
    input  logic [NIB_N-1:0]  chk_par,
    output logic [CHK_W-1:0]  check
);
    always_comb begin
        nib_par = '0;
        check   = '0;
        for (int k = 0; k < NIB_N; k++) nib_par[k] = ^nib_data[4*k +: 4];
        // low checks take one bit of each low nibble, high checks one bit of each high nibble
        for (int j = 0; j < CHK_W; j++) begin
            check[j] = chk_par[PAR_A[j]] ^ chk_par[PAR_B[j]];
            for (int m = 0; m < 4; m++) check[j] = check[j] ^ chk_data[(j < 4 ? 0 : 16) + 4*m + (j % 4)];
        end
    end
endmodule

// File: rtl/sec32_encoder.sv
// sec32_encoder: two-stage elastic SEC encoder with one-shot error injection and saturating word counter
module sec32_encoder
    import sec32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              inj_load,
    input  logic [CW_W-1:0]   inj_mask,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_check,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_cnt
);
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
    logic [NIB_N-1:0]  s1_par_q, s1_par_d, nib_par;
    logic [CW_W-1:0]   s1_mask_q, s1_mask_d, pend_q, pend_d;
    logic [CHK_W-1:0]  s2_check_q, s2_check_d, check;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s2_free, accept, s2_load, out_fire;

    sec32_check_gen u_gen (
        .nib_data(in_data),
        .nib_par (nib_par),
        .chk_data(s1_data_q),
        .chk_par (s1_par_q),
        .check   (check)
    );

    always_comb begin
        s2_free    = !s2_valid_q || out_ready;
        in_ready   = !rst && (!s1_valid_q || s2_free);
        accept     = in_valid && in_ready;
        s2_load    = s1_valid_q && s2_free;
        out_fire   = s2_valid_q && out_ready;
        s1_valid_d = accept || (s1_valid_q && !s2_free);
        s1_data_d  = accept ? in_data : s1_data_q;
        s1_par_d   = accept ? nib_par : s1_par_q;
        // the mask rides with its word so check bits are computed on clean data
        s1_mask_d  = accept ? (inj_load ? inj_mask : pend_q) : s1_mask_q;
        pend_d     = accept ? '0 : (inj_load ? inj_mask : pend_q);
        s2_valid_d = s2_free ? s1_valid_q : 1'b1;
        s2_data_d  = s2_load ? s1_data_q ^ s1_mask_q[DATA_W-1:0] : s2_data_q;
        s2_check_d = s2_load ? check ^ s1_mask_q[CW_W-1:DATA_W] : s2_check_q;
        cnt_d      = (out_fire && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_par_q   <= '0;
            s1_mask_q  <= '0;
            pend_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_check_q <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_par_q   <= s1_par_d;
            s1_mask_q  <= s1_mask_d;
            pend_q     <= pend_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_check_q <= s2_check_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_check = s2_check_q;
    assign word_cnt  = cnt_q;
endmodule

// File: tb/tb_sec32_encoder.sv
// tb_sec32_encoder: directed and random checks of the SEC32 encoder against a reference SEC decoder
module tb_sec32_encoder;
    import sec32_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        inj_load = 1'b0;
    logic [39:0] inj_mask = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, in_ready4, out_valid4;
    logic [31:0] out_data, out_data4;
    logic [7:0]  out_check, out_check4;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt4;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sec32_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .inj_load(inj_load), .inj_mask(inj_mask), .out_valid(out_valid), .out_data(out_data),
        .out_check(out_check), .out_ready(out_ready), .word_cnt(word_cnt)
    );

    sec32_encoder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
        .inj_load(inj_load), .inj_mask(inj_mask), .out_valid(out_valid4), .out_data(out_data4),
        .out_check(out_check4), .out_ready(out_ready), .word_cnt(word_cnt4)
    );

    function automatic logic [31:0] decode(input logic [31:0] d, input logic [7:0] c, output logic [7:0] syn);
        syn = c ^ check_of(d);
        decode = d;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] col;
            for (int j = 0; j < 8; j++) col[j] = CHK_MASK[j][i];
            if (syn != 8'h00 && col == syn) decode[i] = ~d[i];
        end
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; inj_load = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0 || out_check !== 8'h0) begin errors++; $display("FAIL reset_out_word got %h/%h want 0/0", out_data, out_check); end
        checks++; if (word_cnt !== 16'h0) begin errors++; $display("FAIL reset_word_cnt got %0d want 0", word_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        in_valid = 1'b0; rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_vectors;
        logic [31:0] vd [4] = '{32'h0000_0000, 32'h0000_0001, 32'h0001_0000, 32'hFFFF_FFFF};
        logic [7:0]  vc [4] = '{8'h00, 8'h51, 8'h15, 8'h00};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = vd[i]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_early_valid got %b want 0", i, out_valid); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_valid got %b want 1", i, out_valid); end
            checks++; if (out_data !== vd[i] || out_check !== vc[i]) begin errors++; $display("FAIL vec%0d_word got %h/%h want %h/%h", i, out_data, out_check, vd[i], vc[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [31:0] q [$];
        logic [31:0] exp_d, cor;
        logic [7:0]  syn;
        int sent = 0, rcvd = 0, cyc = 0;
        logic acc = 1'b0;
        do_reset;
        while (rcvd < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (acc) begin in_valid = 1'b0; acc = 1'b0; end
            if (!in_valid && sent < 1000) begin in_valid = 1'b1; in_data = $urandom; end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                exp_d = (q.size() > 0) ? q.pop_front() : ~out_data;
                cor = decode(out_data, out_check, syn);
                checks++; if (out_data !== exp_d) begin errors++; $display("FAIL rand_order word %0d got %h want %h", rcvd, out_data, exp_d); end
                checks++; if (syn !== 8'h00 || cor !== out_data) begin errors++; $display("FAIL rand_syndrome word %0d got %h want 00", rcvd, syn); end
                rcvd++;
            end
            if (in_valid && in_ready) begin q.push_back(in_data); sent++; acc = 1'b1; end
        end
        checks++; if (rcvd != 1000) begin errors++; $display("FAIL rand_timeout got %0d words want 1000", rcvd); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (word_cnt !== 16'd1000) begin errors++; $display("FAIL rand_word_cnt got %0d want 1000", word_cnt); end
        checks++; if (word_cnt4 !== 4'd15) begin errors++; $display("FAIL rand_word_cnt4 got %0d want 15", word_cnt4); end
    endtask

    task automatic test_backpressure;
        logic [31:0] w [3] = '{32'h0000_0001, 32'h0001_0000, 32'hDEAD_BEEF};
        int idx = 0;
        logic stable = 1'b1;
        do_reset;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 3 && (out_data !== w[0] || out_check !== 8'h51 || out_valid !== 1'b1)) stable = 1'b0;
            in_valid = 1'b1; in_data = w[idx]; out_ready = 1'b0;
            #1;
            if (in_ready) idx++;
        end
        checks++; if (idx != 2) begin errors++; $display("FAIL bp_absorbed got %0d want 2", idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        checks++; if (!stable) begin errors++; $display("FAIL bp_stable got %h/%h want %h/51", out_data, out_check, w[0]); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== w[0] || out_check !== 8'h51) begin errors++; $display("FAIL bp_drain0 got %b %h/%h want 1 %h/51", out_valid, out_data, out_check, w[0]); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== w[1] || out_check !== 8'h15) begin errors++; $display("FAIL bp_drain1 got %b %h/%h want 1 %h/15", out_valid, out_data, out_check, w[1]); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || word_cnt !== 16'd2) begin errors++; $display("FAIL bp_empty got %b cnt %0d want 0 cnt 2", out_valid, word_cnt); end
    endtask

    task automatic test_inject;
        logic [31:0] cor;
        logic [7:0]  syn;
        do_reset;
        @(negedge clk);
        inj_load = 1'b1; inj_mask = 40'h00_0000_0004; out_ready = 1'b1;
        @(negedge clk);
        inj_load = 1'b0; in_valid = 1'b1; in_data = 32'h0;
        @(negedge clk);
        in_data = 32'h0;
        @(negedge clk);
        in_valid = 1'b0;
        cor = decode(out_data, out_check, syn);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h4 || out_check !== 8'h00) begin errors++; $display("FAIL inj_word got %b %h/%h want 1 00000004/00", out_valid, out_data, out_check); end
        checks++; if (cor !== 32'h0 || syn !== 8'h54) begin errors++; $display("FAIL inj_correct got %h syn %h want 00000000 syn 54", cor, syn); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0 || out_check !== 8'h00) begin errors++; $display("FAIL inj_next got %b %h/%h want 1 00000000/00", out_valid, out_data, out_check); end
        inj_load = 1'b1; inj_mask = 40'hFF_0000_0000;
        @(negedge clk);
        inj_load = 1'b1; inj_mask = 40'h01_8000_0000; in_valid = 1'b1; in_data = 32'h1;
        @(negedge clk);
        inj_load = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h8000_0001 || out_check !== 8'h50) begin errors++; $display("FAIL inj_overwrite got %b %h/%h want 1 80000001/50", out_valid, out_data, out_check); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        do_reset;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL mid_pre_cnt got %0d want 1", word_cnt); end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        @(negedge clk);
        in_data = 32'hB;
        @(negedge clk);
        in_valid = 1'b0; inj_load = 1'b1; inj_mask = 40'hFF_FFFF_FFFF;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %b/%b want 1/0", out_valid, in_ready); end
        @(negedge clk);
        inj_load = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || word_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset got %b cnt %0d want 0 cnt 0", out_valid, word_cnt); end
        in_valid = 1'b1; in_data = 32'h0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0 || out_check !== 8'h00) begin errors++; $display("FAIL mid_pend_cleared got %b %h/%h want 1 00000000/00", out_valid, out_data, out_check); end
        @(negedge clk);
    endtask

    task automatic test_saturate;
        do_reset;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'(i); out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (word_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16 got %0d want 20", word_cnt); end
        checks++; if (word_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got %0d want 15", word_cnt4); end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_random;
        test_backpressure;
        test_inject;
        test_reset_mid;
        test_saturate;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
